// File: rtl/ex_mem_stage.sv
// EX stage with EX/MEM pipeline register: operand forwarding, ALU, branch target,
// and a registered output bundle with stall/flush/reset control.
module ex_mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        regDest,
    input  logic [1:0]  aluOp,
    input  logic        aluSrc,
    input  logic [2:0]  memControlIdEx,
    input  logic [1:0]  wbControlIdEx,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] signExtendWire,
    input  logic [31:0] ifId,
    input  logic [4:0]  rd,
    input  logic [4:0]  rt,
    input  logic [4:0]  rs,
    input  logic        memWbRegWrite,
    input  logic [4:0]  memWbRd,
    input  logic [31:0] memWbData,
    output logic [31:0] aluResult,
    output logic [31:0] writeData,
    output logic [4:0]  writeReg,
    output logic        zero,
    output logic [31:0] branchTarget,
    output logic [2:0]  memControlExMem,
    output logic [1:0]  wbControlExMem
);

    logic [31:0] fwdA;
    logic [31:0] fwdB;
    logic [31:0] opB;
    logic [31:0] aluOut;
    logic [31:0] targetNext;
    logic [4:0]  destNext;
    logic        exMemWrites;

    // The held EX/MEM entry is the youngest producer, so it outranks MEM/WB.
    assign exMemWrites = wbControlExMem[1] && (writeReg != 5'd0);

    always_comb begin
        fwdA = readData1;
        if (exMemWrites && (writeReg == rs))
            fwdA = aluResult;
        else if (memWbRegWrite && (memWbRd != 5'd0) && (memWbRd == rs))
            fwdA = memWbData;

        fwdB = readData2;
        if (exMemWrites && (writeReg == rt))
            fwdB = aluResult;
        else if (memWbRegWrite && (memWbRd != 5'd0) && (memWbRd == rt))
            fwdB = memWbData;
    end

    assign opB        = aluSrc ? signExtendWire : fwdB;
    assign destNext   = regDest ? rd : rt;
    assign targetNext = ifId + {signExtendWire[29:0], 2'b00};

    always_comb begin
        aluOut = 32'd0;
        case (aluOp)
            2'b00: aluOut = fwdA + opB;
            2'b01: aluOut = fwdA - opB;
            2'b11: aluOut = fwdA & opB;
            2'b10: begin
                case (signExtendWire[5:0])
                    6'h20:   aluOut = fwdA + opB;
                    6'h22:   aluOut = fwdA - opB;
                    6'h24:   aluOut = fwdA & opB;
                    6'h25:   aluOut = fwdA | opB;
                    6'h27:   aluOut = ~(fwdA | opB);
                    6'h2A:   aluOut = {31'd0, ($signed(fwdA) < $signed(opB))};
                    default: aluOut = 32'd0;
                endcase
            end
            default: aluOut = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            aluResult       <= 32'd0;
            writeData       <= 32'd0;
            writeReg        <= 5'd0;
            zero            <= 1'b0;
            branchTarget    <= 32'd0;
            memControlExMem <= 3'd0;
            wbControlExMem  <= 2'd0;
        end else if (!stall) begin
            aluResult       <= aluOut;
            writeData       <= fwdB;
            writeReg        <= destNext;
            zero            <= (aluOut == 32'd0);
            branchTarget    <= targetNext;
            memControlExMem <= memControlIdEx;
            wbControlExMem  <= wbControlIdEx;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a randomized
// run against a behavioural model of the EX/MEM register.
module tb_ex_mem_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush, regDest, aluSrc, memWbRegWrite;
    logic [1:0]  aluOp, wbControlIdEx;
    logic [2:0]  memControlIdEx;
    logic [31:0] readData1, readData2, signExtendWire, ifId, memWbData;
    logic [4:0]  rd, rt, rs, memWbRd;
    logic [31:0] aluResult, writeData, branchTarget;
    logic [4:0]  writeReg;
    logic        zero;
    logic [2:0]  memControlExMem;
    logic [1:0]  wbControlExMem;

    // Model of the EX/MEM register contents
    logic [31:0] e_alu, e_wd, e_bt;
    logic [4:0]  e_wr;
    logic        e_zero;
    logic [2:0]  e_mem;
    logic [1:0]  e_wb;

    int errors = 0;
    int checks = 0;

    ex_mem_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .regDest(regDest), .aluOp(aluOp), .aluSrc(aluSrc),
        .memControlIdEx(memControlIdEx), .wbControlIdEx(wbControlIdEx),
        .readData1(readData1), .readData2(readData2),
        .signExtendWire(signExtendWire), .ifId(ifId),
        .rd(rd), .rt(rt), .rs(rs),
        .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
        .aluResult(aluResult), .writeData(writeData), .writeReg(writeReg),
        .zero(zero), .branchTarget(branchTarget),
        .memControlExMem(memControlExMem), .wbControlExMem(wbControlExMem)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] idex);
        if (e_wb[1] && r != 0 && r == e_wr) return e_alu;
        if (memWbRegWrite && r != 0 && r == memWbRd) return memWbData;
        return idex;
    endfunction

    function automatic logic [31:0] compute(input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a; sb = b;
        if (aluOp == 2'b00) return a + b;
        if (aluOp == 2'b01) return a - b;
        if (aluOp == 2'b11) return a & b;
        case (signExtendWire[5:0])
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h27: return ~(a | b);
            6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock and update the model; outputs are then stable at +1.
    task automatic step();
        logic [31:0] a, b, r;
        a = pick(rs, readData1);
        b = pick(rt, readData2);
        r = compute(a, aluSrc ? signExtendWire : b);
        @(posedge clock);
        #1;
        if (reset || flush) begin
            e_alu = 0; e_wd = 0; e_wr = 0; e_zero = 0; e_bt = 0; e_mem = 0; e_wb = 0;
        end else if (!stall) begin
            e_alu = r; e_wd = b; e_wr = regDest ? rd : rt; e_zero = (r == 0);
            e_bt = ifId + signExtendWire * 4; e_mem = memControlIdEx; e_wb = wbControlIdEx;
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; regDest = 0; aluSrc = 0; aluOp = 0;
        memWbRegWrite = 0; memWbRd = 0; memWbData = 0; wbControlIdEx = 0;
        memControlIdEx = 0; readData1 = 0; readData2 = 0; signExtendWire = 0;
        ifId = 0; rd = 0; rt = 0; rs = 0;
    endtask

    task automatic test_reset();
        idle();
        readData1 = 32'h55; ifId = 32'h40; wbControlIdEx = 2'b11; memControlIdEx = 3'b111;
        reset = 1; stall = 1; flush = 1;
        step();
        checks++; if (aluResult !== 0) begin errors++; $display("FAIL reset_alu got=%h exp=0", aluResult); end
        checks++; if (writeData !== 0) begin errors++; $display("FAIL reset_wd got=%h exp=0", writeData); end
        checks++; if (writeReg !== 0) begin errors++; $display("FAIL reset_wr got=%0d exp=0", writeReg); end
        checks++; if (zero !== 0) begin errors++; $display("FAIL reset_zero got=%b exp=0", zero); end
        checks++; if (branchTarget !== 0) begin errors++; $display("FAIL reset_bt got=%h exp=0", branchTarget); end
        checks++; if ({memControlExMem, wbControlExMem} !== 5'd0) begin errors++;
            $display("FAIL reset_ctl got=%b exp=00000", {memControlExMem, wbControlExMem}); end
        idle();
    endtask

    task automatic test_rtype_add();
        idle();
        aluOp = 2'b10; signExtendWire = 32'h20; rs = 1; rt = 2; readData1 = 5; readData2 = 7;
        regDest = 1; rd = 3; wbControlIdEx = 2'b10;
        step();
        checks++; if (aluResult !== 32'd12) begin errors++; $display("FAIL add_alu got=%0d exp=12", aluResult); end
        checks++; if (writeReg !== 5'd3) begin errors++; $display("FAIL add_wr got=%0d exp=3", writeReg); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got=%b exp=0", zero); end
        checks++; if (writeData !== 32'd7) begin errors++; $display("FAIL add_wd got=%0d exp=7", writeData); end
    endtask

    task automatic test_back_to_back();
        idle();
        aluOp = 2'b00; readData1 = 32'h10; regDest = 1; rd = 8; wbControlIdEx = 2'b10;
        step();
        checks++; if (aluResult !== 32'h10 || writeReg !== 5'd8) begin errors++;
            $display("FAIL b2b_first got=%h/%0d exp=10/8", aluResult, writeReg); end
        idle();
        aluOp = 2'b01; rs = 8; readData1 = 0; rt = 9; readData2 = 32'h10;
        step();
        checks++; if (aluResult !== 32'd0) begin errors++; $display("FAIL b2b_alu got=%h exp=0", aluResult); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL b2b_zero got=%b exp=1", zero); end
    endtask

    task automatic test_double_match();
        idle();
        aluOp = 2'b00; readData1 = 9; regDest = 1; rd = 4; wbControlIdEx = 2'b10;
        step();
        idle();
        memWbRegWrite = 1; memWbRd = 4; memWbData = 2; rs = 4; readData1 = 100;
        aluOp = 2'b00; regDest = 0; rt = 0;
        step();
        checks++; if (aluResult !== 32'd9) begin errors++; $display("FAIL dbl_exmem got=%0d exp=9", aluResult); end
        // EX/MEM now holds writeReg=0, so only MEM/WB can supply r4
        step();
        checks++; if (aluResult !== 32'd2) begin errors++; $display("FAIL dbl_memwb got=%0d exp=2", aluResult); end
        rs = 0; memWbRd = 0; readData1 = 77;
        step();
        checks++; if (aluResult !== 32'd77) begin errors++; $display("FAIL reg0_fwd got=%0d exp=77", aluResult); end
        rt = 4; memWbRd = 4; readData2 = 5; aluSrc = 1; signExtendWire = 1; readData1 = 0; rs = 0;
        step();
        checks++; if (writeData !== 32'd2 || aluResult !== 32'd1) begin errors++;
            $display("FAIL store_fwd got=%0d/%0d exp=2/1", writeData, aluResult); end
    endtask

    task automatic test_branch();
        idle();
        ifId = 32'h100; signExtendWire = 32'hFFFF_FFFF; aluOp = 2'b01; memControlIdEx = 3'b100;
        step();
        checks++; if (branchTarget !== 32'h0000_00FC) begin errors++;
            $display("FAIL branch_target got=%h exp=000000fc", branchTarget); end
        checks++; if (memControlExMem !== 3'b100) begin errors++;
            $display("FAIL branch_ctl got=%b exp=100", memControlExMem); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] hold;
        idle();
        aluOp = 2'b00; readData1 = 32'h1234; readData2 = 32'h11; ifId = 32'h8; rd = 6; regDest = 1;
        wbControlIdEx = 2'b11; memControlIdEx = 3'b010;
        step();
        hold = aluResult;
        checks++; if (hold !== 32'h1245) begin errors++; $display("FAIL sf_load got=%h exp=1245", hold); end
        for (int i = 0; i < 2; i++) begin
            stall = 1; readData1 = $urandom; readData2 = $urandom; rd = 5'($urandom);
            wbControlIdEx = 2'b00; memControlIdEx = 3'b101; ifId = $urandom;
            step();
            checks++; if (aluResult !== 32'h1245 || writeReg !== 5'd6 || wbControlExMem !== 2'b11
                          || memControlExMem !== 3'b010 || branchTarget !== 32'h8 || writeData !== 32'h11) begin
                errors++; $display("FAIL stall_hold got=%h/%0d/%b/%b exp=1245/6/11/010",
                                   aluResult, writeReg, wbControlExMem, memControlExMem);
            end
        end
        flush = 1; stall = 1;
        step();
        checks++; if ({aluResult, writeData, branchTarget} !== 96'd0 || writeReg !== 0 || zero !== 0
                      || memControlExMem !== 0 || wbControlExMem !== 0) begin
            errors++; $display("FAIL flush_over_stall got=%h/%h/%0d/%b exp=all zero",
                               aluResult, writeData, writeReg, wbControlExMem);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        readData1 = 3; readData2 = 4; aluOp = 2'b00; wbControlIdEx = 2'b10; rt = 7;
        step();
        stall = 1; reset = 1; readData1 = 50;
        step();
        checks++; if (aluResult !== 0 || writeReg !== 0 || wbControlExMem !== 0) begin errors++;
            $display("FAIL reset_mid got=%h/%0d/%b exp=0/0/00", aluResult, writeReg, wbControlExMem); end
        reset = 0; stall = 0; readData1 = 20; readData2 = 22; rt = 5; aluOp = 2'b01; wbControlIdEx = 2'b01;
        step();
        checks++; if (aluResult !== 32'hFFFF_FFFE || writeReg !== 5'd5 || wbControlExMem !== 2'b01) begin
            errors++; $display("FAIL reset_release got=%h/%0d/%b exp=fffffffe/5/01",
                               aluResult, writeReg, wbControlExMem);
        end
    endtask

    task automatic test_random();
        logic [5:0] functs [7];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            regDest = 1'($urandom); aluSrc = ($urandom_range(0, 3) == 0);
            aluOp = 2'($urandom); memControlIdEx = 3'($urandom); wbControlIdEx = 2'($urandom);
            rs = 5'($urandom_range(0, 5)); rt = 5'($urandom_range(0, 5)); rd = 5'($urandom_range(0, 5));
            memWbRegWrite = 1'($urandom); memWbRd = 5'($urandom_range(0, 5)); memWbData = $urandom;
            readData1 = $urandom;
            readData2 = ($urandom_range(0, 3) == 0) ? readData1 : $urandom;
            signExtendWire = $urandom;
            if (aluOp == 2'b10) signExtendWire[5:0] = functs[$urandom_range(0, 6)];
            ifId = $urandom;
            step();
            checks++; if (aluResult !== e_alu) begin errors++;
                $display("FAIL rnd_alu n=%0d got=%h exp=%h", n, aluResult, e_alu); end
            checks++; if (writeData !== e_wd) begin errors++;
                $display("FAIL rnd_wd n=%0d got=%h exp=%h", n, writeData, e_wd); end
            checks++; if (writeReg !== e_wr) begin errors++;
                $display("FAIL rnd_wr n=%0d got=%0d exp=%0d", n, writeReg, e_wr); end
            checks++; if (zero !== e_zero) begin errors++;
                $display("FAIL rnd_zero n=%0d got=%b exp=%b", n, zero, e_zero); end
            checks++; if (branchTarget !== e_bt) begin errors++;
                $display("FAIL rnd_bt n=%0d got=%h exp=%h", n, branchTarget, e_bt); end
            checks++; if (memControlExMem !== e_mem || wbControlExMem !== e_wb) begin errors++;
                $display("FAIL rnd_ctl n=%0d got=%b/%b exp=%b/%b", n, memControlExMem, wbControlExMem, e_mem, e_wb); end
        end
        idle();
    endtask

    initial begin
        idle();
        e_alu = 0; e_wd = 0; e_wr = 0; e_zero = 0; e_bt = 0; e_mem = 0; e_wb = 0;
        #2;
        test_reset();
        test_rtype_add();
        test_back_to_back();
        test_double_match();
        test_branch();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
